// File: rtl/rv32_pkg.sv
// RV32IM shared decode definitions: opcodes, ALU operation codes, immediate formats.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB, ALU_AUIPC,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } aluop_e;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // alt selects SUB/SRA on the funct3 slots that have an alternate form
  function automatic aluop_e base_aluop(input logic [2:0] funct3, input logic alt);
    aluop_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic aluop_e muldiv_aluop(input logic [2:0] funct3);
    aluop_e op;
    case (funct3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: sign-extended immediate for the selected RV32 format.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32IM instruction-decode stage: control decode, load-use hazard detection,
// write-back bypass and the ID/EX pipeline register.
module id_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IF_VALID,
  input  logic [31:0]     IF_INSTR,
  input  logic [31:0]     IF_PC,
  input  logic            FLUSH,
  input  logic            EX_STALL,
  output logic            STALL_OUT,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            WB_WRITEENABLE,
  input  logic [4:0]      WB_WRITEADDRESS,
  input  logic [XLEN-1:0] WB_WRITEDATA,
  output logic            EX_VALID,
  output logic [31:0]     EX_PC,
  output logic [XLEN-1:0] EX_DATA1,
  output logic [XLEN-1:0] EX_DATA2,
  output logic [31:0]     EX_IMM,
  output logic [4:0]      EX_RS1,
  output logic [4:0]      EX_RS2,
  output logic [4:0]      EX_RD,
  output logic [4:0]      EX_ALUOP,
  output logic [2:0]      EX_FUNCT3,
  output logic            EX_ALUSRC,
  output logic            EX_REGWRITE,
  output logic            EX_MEMREAD,
  output logic            EX_MEMWRITE,
  output logic            EX_BRANCH,
  output logic            EX_JUMP,
  output logic            EX_MULDIV,
  output logic            EX_ILLEGAL
);

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      aluop;
    logic [2:0]      funct3;
    logic            alusrc;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            jump;
    logic            muldiv;
    logic            illegal;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '{pc: RESET_PC, default: '0};

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;

  assign opcode = IF_INSTR[6:0];
  assign funct3 = IF_INSTR[14:12];
  assign funct7 = IF_INSTR[31:25];
  assign rd     = IF_INSTR[11:7];
  assign RS1    = IF_INSTR[19:15];
  assign RS2    = IF_INSTR[24:20];

  aluop_e   alu_op;
  imm_fmt_e imm_fmt;
  logic     alu_src, reg_write, mem_read, mem_write, branch, jump, muldiv, illegal;
  logic     use_rs1, use_rs2;

  always_comb begin
    alu_op    = ALU_ADD;
    imm_fmt   = IMM_R;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    muldiv    = 1'b0;
    illegal   = 1'b0;
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    case (opcode)
      OPC_LOAD:   begin imm_fmt = IMM_I; alu_src = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
      OPC_STORE:  begin imm_fmt = IMM_S; alu_src = 1'b1; mem_write = 1'b1; use_rs2 = 1'b1; end
      OPC_BRANCH: begin imm_fmt = IMM_B; alu_op = ALU_SUB; branch = 1'b1; use_rs2 = 1'b1; end
      OPC_JAL:    begin imm_fmt = IMM_J; alu_src = 1'b1; reg_write = 1'b1; jump = 1'b1; use_rs1 = 1'b0; end
      OPC_JALR:   begin imm_fmt = IMM_I; alu_src = 1'b1; reg_write = 1'b1; jump = 1'b1; end
      OPC_LUI:    begin imm_fmt = IMM_U; alu_op = ALU_PASSB; alu_src = 1'b1; reg_write = 1'b1; use_rs1 = 1'b0; end
      OPC_AUIPC:  begin imm_fmt = IMM_U; alu_op = ALU_AUIPC; alu_src = 1'b1; reg_write = 1'b1; use_rs1 = 1'b0; end
      OPC_OP_IMM: begin
        imm_fmt   = IMM_I;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = base_aluop(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        // shift-immediates reuse the funct7 field, so it must be a legal encoding
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
      end
      OPC_OP: begin
        reg_write = 1'b1;
        use_rs2   = 1'b1;
        if (funct7 == F7_MULDIV) begin
          muldiv = 1'b1;
          alu_op = muldiv_aluop(funct3);
        end else if (funct7 == F7_BASE) begin
          alu_op = base_aluop(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          alu_op = base_aluop(funct3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: imm_fmt = IMM_I;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op    = ALU_ADD;
      imm_fmt   = IMM_R;
      alu_src   = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      muldiv    = 1'b0;
    end
    if (rd == '0) reg_write = 1'b0;
  end

  logic [31:0] imm;

  imm_gen u_imm_gen (
    .instr (IF_INSTR[31:7]),
    .fmt   (imm_fmt),
    .imm   (imm)
  );

  logic            hazard, bubble;
  logic [XLEN-1:0] op1, op2;
  id_ex_t          d, q;

  assign hazard = q.valid & q.memread & (q.rd != '0) &
                  ((use_rs1 & (q.rd == RS1)) | (use_rs2 & (q.rd == RS2)));
  // reset term keeps STALL_OUT low while the pipeline is held in reset
  assign STALL_OUT = RESET & ((hazard & IF_VALID & ~FLUSH) | EX_STALL);
  assign bubble    = FLUSH | ~IF_VALID | hazard;

  always_comb begin
    op1 = DATA1;
    if (RS1 == '0) op1 = '0;
    else if (WB_WRITEENABLE && WB_WRITEADDRESS == RS1) op1 = WB_WRITEDATA;
    op2 = DATA2;
    if (RS2 == '0) op2 = '0;
    else if (WB_WRITEENABLE && WB_WRITEADDRESS == RS2) op2 = WB_WRITEDATA;
  end

  always_comb begin
    d = BUBBLE;
    if (!bubble) begin
      d.valid    = 1'b1;
      d.pc       = IF_PC;
      d.data1    = op1;
      d.data2    = op2;
      d.imm      = imm;
      d.rs1      = RS1;
      d.rs2      = RS2;
      d.rd       = rd;
      d.aluop    = alu_op;
      d.funct3   = funct3;
      d.alusrc   = alu_src;
      d.regwrite = reg_write;
      d.memread  = mem_read;
      d.memwrite = mem_write;
      d.branch   = branch;
      d.jump     = jump;
      d.muldiv   = muldiv;
      d.illegal  = illegal;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         q <= BUBBLE;
    else if (!EX_STALL) q <= d;
  end

  assign EX_VALID    = q.valid;
  assign EX_PC       = q.pc;
  assign EX_DATA1    = q.data1;
  assign EX_DATA2    = q.data2;
  assign EX_IMM      = q.imm;
  assign EX_RS1      = q.rs1;
  assign EX_RS2      = q.rs2;
  assign EX_RD       = q.rd;
  assign EX_ALUOP    = q.aluop;
  assign EX_FUNCT3   = q.funct3;
  assign EX_ALUSRC   = q.alusrc;
  assign EX_REGWRITE = q.regwrite;
  assign EX_MEMREAD  = q.memread;
  assign EX_MEMWRITE = q.memwrite;
  assign EX_BRANCH   = q.branch;
  assign EX_JUMP     = q.jump;
  assign EX_MULDIV   = q.muldiv;
  assign EX_ILLEGAL  = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: instruction-level reference model plus directed literal checks.
module tb_id_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int BASE_TAB [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  logic        CLK = 1'b0, RESET = 1'b0;
  logic        IF_VALID = 1'b0, FLUSH = 1'b0, EX_STALL = 1'b0, WB_WRITEENABLE = 1'b0;
  logic [31:0] IF_INSTR = '0, IF_PC = '0, DATA1 = '0, DATA2 = '0, WB_WRITEDATA = '0;
  logic [4:0]  WB_WRITEADDRESS = '0;
  logic        STALL_OUT, EX_VALID, EX_ALUSRC, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE;
  logic        EX_BRANCH, EX_JUMP, EX_MULDIV, EX_ILLEGAL;
  logic [4:0]  RS1, RS2, EX_RS1, EX_RS2, EX_RD, EX_ALUOP;
  logic [2:0]  EX_FUNCT3;
  logic [31:0] EX_PC, EX_DATA1, EX_DATA2, EX_IMM;

  int tests = 0;
  int fails = 0;

  id_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC),
    .FLUSH(FLUSH), .EX_STALL(EX_STALL), .STALL_OUT(STALL_OUT), .RS1(RS1), .RS2(RS2),
    .DATA1(DATA1), .DATA2(DATA2), .WB_WRITEENABLE(WB_WRITEENABLE),
    .WB_WRITEADDRESS(WB_WRITEADDRESS), .WB_WRITEDATA(WB_WRITEDATA),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2),
    .EX_IMM(EX_IMM), .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_ALUOP(EX_ALUOP),
    .EX_FUNCT3(EX_FUNCT3), .EX_ALUSRC(EX_ALUSRC), .EX_REGWRITE(EX_REGWRITE),
    .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE), .EX_BRANCH(EX_BRANCH),
    .EX_JUMP(EX_JUMP), .EX_MULDIV(EX_MULDIV), .EX_ILLEGAL(EX_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd, aluop;
    logic [2:0]  f3;
    logic        alusrc, rw, mr, mw, br, j, md, ill;
  } st_t;

  st_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic st_t empty_state();
    st_t s;
    s = '0;
    s.pc = RPC;
    return s;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf,
                                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return rf;
  endfunction

  function automatic st_t decode_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] d1, input logic [31:0] d2, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
    st_t s;
    int op, f3, f7, b, jv;
    logic signed [31:0] sw;
    logic [31:0] iimm;
    s = '0;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    sw = $signed(ins);
    iimm = sw >>> 20;
    b  = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    jv = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    s.valid = 1'b1;
    s.pc  = pc;
    s.rs1 = ins[19:15];
    s.rs2 = ins[24:20];
    s.rd  = ins[11:7];
    s.f3  = ins[14:12];
    s.d1  = operand(ins[19:15], d1, we, wa, wd);
    s.d2  = operand(ins[24:20], d2, we, wa, wd);
    case (op)
      'h03: begin s.mr = 1; s.rw = 1; s.alusrc = 1; s.imm = iimm; end
      'h23: begin s.mw = 1; s.alusrc = 1; s.imm = (iimm & 32'hFFFF_FFE0) | {27'd0, ins[11:7]}; end
      'h63: begin s.br = 1; s.aluop = 5'd1; s.imm = 32'(b); end
      'h6F: begin s.j = 1; s.rw = 1; s.alusrc = 1; s.imm = 32'(jv); end
      'h67: begin s.j = 1; s.rw = 1; s.alusrc = 1; s.imm = iimm; end
      'h37: begin s.aluop = 5'd10; s.rw = 1; s.alusrc = 1; s.imm = ins & 32'hFFFF_F000; end
      'h17: begin s.aluop = 5'd11; s.rw = 1; s.alusrc = 1; s.imm = ins & 32'hFFFF_F000; end
      'h13: begin
        s.rw = 1; s.alusrc = 1; s.imm = iimm;
        s.aluop = 5'(BASE_TAB[f3]);
        if (f3 == 1 && f7 != 0) s.ill = 1;
        if (f3 == 5) begin
          if (f7 == 'h20) s.aluop = 5'd7;
          else if (f7 != 0) s.ill = 1;
        end
      end
      'h33: begin
        s.rw = 1;
        if (f7 == 1) begin s.md = 1; s.aluop = 5'(12 + f3); end
        else if (f7 == 0) s.aluop = 5'(BASE_TAB[f3]);
        else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) s.aluop = 5'(BASE_TAB[f3] + 1);
        else s.ill = 1;
      end
      'h0F, 'h73: s.imm = iimm;
      default: s.ill = 1;
    endcase
    if (s.ill) begin
      s.rw = 0; s.mr = 0; s.mw = 0; s.br = 0; s.j = 0; s.md = 0; s.alusrc = 0;
      s.aluop = '0; s.imm = '0;
    end
    if (s.rd == 5'd0) s.rw = 0;
    return s;
  endfunction

  function automatic logic load_use(input st_t e, input logic [31:0] ins);
    logic reads1, reads2;
    reads1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
    reads2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
    return e.valid && e.mr && e.rd != 0 &&
           ((reads1 && e.rd == ins[19:15]) || (reads2 && e.rd == ins[24:20]));
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) m <= empty_state();
    else if (!EX_STALL) begin
      if (FLUSH || !IF_VALID || load_use(m, IF_INSTR)) m <= empty_state();
      else m <= decode_model(IF_INSTR, IF_PC, DATA1, DATA2, WB_WRITEENABLE, WB_WRITEADDRESS, WB_WRITEDATA);
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      if (FLUSH && EX_STALL) begin
        fails++;
        $display("FAIL flush_while_stalled: FLUSH=1 with EX_STALL=1 at %0t", $time);
      end
      chk("rs1_addr", 32'(RS1), (IF_INSTR >> 15) & 32'h1F);
      chk("rs2_addr", 32'(RS2), (IF_INSTR >> 20) & 32'h1F);
      chk("stall_out", 32'(STALL_OUT), 32'((load_use(m, IF_INSTR) && IF_VALID && !FLUSH) || EX_STALL));
      chk("ex_valid", 32'(EX_VALID), 32'(m.valid));
      chk("ex_pc", EX_PC, m.pc);
      chk("ex_data1", EX_DATA1, m.d1);
      chk("ex_data2", EX_DATA2, m.d2);
      chk("ex_imm", EX_IMM, m.imm);
      chk("ex_rs1", 32'(EX_RS1), 32'(m.rs1));
      chk("ex_rs2", 32'(EX_RS2), 32'(m.rs2));
      chk("ex_rd", 32'(EX_RD), 32'(m.rd));
      chk("ex_aluop", 32'(EX_ALUOP), 32'(m.aluop));
      chk("ex_funct3", 32'(EX_FUNCT3), 32'(m.f3));
      chk("ex_ctrl", {24'd0, EX_ALUSRC, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_BRANCH, EX_JUMP, EX_MULDIV, EX_ILLEGAL},
          {24'd0, m.alusrc, m.rw, m.mr, m.mw, m.br, m.j, m.md, m.ill});
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
    IF_VALID = v; IF_INSTR = ins; IF_PC = pc; DATA1 = d1; DATA2 = d2;
    WB_WRITEENABLE = 1'b0; WB_WRITEADDRESS = '0; WB_WRITEDATA = '0;
    FLUSH = 1'b0; EX_STALL = 1'b0;
  endtask

  localparam logic [31:0] ADDI_X1   = 32'h0050_0093;
  localparam logic [31:0] ADD_X3    = 32'h0020_81B3;
  localparam logic [31:0] LW_X5     = 32'h0003_2283;
  localparam logic [31:0] ADD_RS1X5 = 32'h0012_83B3;
  localparam logic [31:0] ADD_RS2X5 = 32'h0050_83B3;
  localparam logic [31:0] LUI_X5    = 32'h1234_52B7;
  localparam logic [31:0] MUL_X4    = 32'h0231_0233;
  localparam logic [31:0] BEQ_M8    = 32'hFE00_0CE3;
  localparam logic [31:0] BAD_OPC   = 32'h0000_0FFF;

  typedef struct packed { logic v; logic [31:0] ins; } vec_t;
  localparam vec_t VECS [16] = '{
    '{1'b1, 32'h0000_0013}, '{1'b1, 32'h4031_00B3}, '{1'b1, 32'h4031_5093},
    '{1'b1, 32'h0020_A423}, '{1'b1, 32'h0100_00EF}, '{1'b1, 32'h0000_8067},
    '{1'b1, 32'h0000_1117}, '{1'b1, 32'h0000_0073}, '{1'b1, 32'h0000_000F},
    '{1'b1, 32'h8000_0033}, '{1'b1, 32'h0231_5233}, '{1'b0, 32'h0020_81B3},
    '{1'b1, 32'h0003_2003}, '{1'b1, 32'h0000_03B3}, '{1'b1, 32'h8000_1093},
    '{1'b1, 32'hFFF0_0113}
  };

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", 32'(EX_VALID), 32'd0);
    chk("rst_pc", EX_PC, RPC);
    chk("rst_stall", 32'(STALL_OUT), 32'd0);
    RESET = 1'b1;

    set_in(1, ADDI_X1, 32'h1000, 32'hDEAD, 32'h0);
    cyc();
    chk("addi_valid", 32'(EX_VALID), 32'd1);
    chk("addi_rd", 32'(EX_RD), 32'd1);
    chk("addi_imm", EX_IMM, 32'd5);
    chk("addi_data1_x0", EX_DATA1, 32'd0);
    chk("addi_alusrc", 32'(EX_ALUSRC), 32'd1);
    chk("addi_regwrite", 32'(EX_REGWRITE), 32'd1);

    set_in(1, ADD_X3, 32'h1004, 32'h1111, 32'h2222);
    WB_WRITEENABLE = 1; WB_WRITEADDRESS = 5'd1; WB_WRITEDATA = 32'hA5A5_A5A5;
    cyc();
    chk("wb_bypass_d1", EX_DATA1, 32'hA5A5_A5A5);
    chk("wb_bypass_d2", EX_DATA2, 32'h2222);
    set_in(1, ADD_X3, 32'h1008, 32'h1111, 32'h2222);
    WB_WRITEENABLE = 1; WB_WRITEADDRESS = 5'd0; WB_WRITEDATA = 32'hA5A5_A5A5;
    cyc();
    chk("wb_addr0_d1", EX_DATA1, 32'h1111);
    set_in(1, ADD_X3, 32'h100C, 32'h1111, 32'h2222);
    WB_WRITEENABLE = 1; WB_WRITEADDRESS = 5'd2; WB_WRITEDATA = 32'h5A5A_5A5A;
    cyc();
    chk("wb_bypass_d2_rs2", EX_DATA2, 32'h5A5A_5A5A);

    for (int k = 0; k < 2; k++) begin
      set_in(1, LW_X5, 32'h1010, 32'h40, 32'h0);
      cyc();
      chk("lw_memread", 32'(EX_MEMREAD), 32'd1);
      set_in(1, (k == 0) ? ADD_RS1X5 : ADD_RS2X5, 32'h1014, 32'h7, 32'h8);
      #1;
      chk("lu_stall", 32'(STALL_OUT), 32'd1);
      cyc();
      chk("lu_bubble", 32'(EX_VALID), 32'd0);
      chk("lu_stall_clear", 32'(STALL_OUT), 32'd0);
      cyc();
      chk("lu_capture_valid", 32'(EX_VALID), 32'd1);
      chk("lu_capture_rd", 32'(EX_RD), 32'd7);
    end

    set_in(1, LW_X5, 32'h1018, 32'h40, 32'h0);
    cyc();
    set_in(1, LUI_X5, 32'h101C, 32'h0, 32'h0);
    #1;
    chk("lui_no_stall", 32'(STALL_OUT), 32'd0);
    cyc();
    chk("lui_valid", 32'(EX_VALID), 32'd1);

    set_in(1, ADDI_X1, 32'h1020, 32'h0, 32'h0);
    FLUSH = 1;
    cyc();
    chk("flush_bubble", 32'(EX_VALID), 32'd0);
    chk("flush_pc", EX_PC, RPC);
    set_in(1, LW_X5, 32'h1024, 32'h40, 32'h0);
    cyc();
    set_in(1, ADD_RS1X5, 32'h1028, 32'h0, 32'h0);
    FLUSH = 1;
    #1;
    chk("flush_masks_hazard", 32'(STALL_OUT), 32'd0);
    cyc();

    set_in(1, ADDI_X1, 32'h1030, 32'h0, 32'h0);
    cyc();
    set_in(1, MUL_X4, 32'h1034, 32'h3, 32'h4);
    EX_STALL = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("exstall_out", 32'(STALL_OUT), 32'd1);
      cyc();
      chk("exstall_hold_imm", EX_IMM, 32'd5);
      chk("exstall_hold_pc", EX_PC, 32'h1030);
    end
    EX_STALL = 0;
    cyc();
    chk("mul_muldiv", 32'(EX_MULDIV), 32'd1);
    chk("mul_aluop", 32'(EX_ALUOP), 32'd12);

    set_in(1, BEQ_M8, 32'h1038, 32'h0, 32'h0);
    cyc();
    chk("beq_imm", EX_IMM, 32'hFFFF_FFF8);
    chk("beq_model_imm", m.imm, 32'hFFFF_FFF8);
    chk("beq_branch", 32'(EX_BRANCH), 32'd1);

    set_in(1, BAD_OPC, 32'h103C, 32'h0, 32'h0);
    cyc();
    chk("illegal_flag", 32'(EX_ILLEGAL), 32'd1);
    chk("illegal_regwrite", 32'(EX_REGWRITE), 32'd0);
    chk("illegal_valid", 32'(EX_VALID), 32'd1);

    for (int k = 0; k < 16; k++) begin
      set_in(VECS[k].v, VECS[k].ins, 32'h2000 + 32'(k) * 4, $urandom, $urandom);
      if (k % 3 == 0) begin
        WB_WRITEENABLE = 1; WB_WRITEADDRESS = 5'(k % 4); WB_WRITEDATA = $urandom;
      end
      cyc();
    end

    set_in(1, ADDI_X1, 32'h3000, 32'h0, 32'h0);
    cyc();
    #1;
    EX_STALL = 1;
    RESET = 0;
    #1;
    chk("async_rst_valid", 32'(EX_VALID), 32'd0);
    chk("async_rst_pc", EX_PC, RPC);
    chk("async_rst_imm", EX_IMM, 32'd0);
    chk("async_rst_rd", 32'(EX_RD), 32'd0);
    chk("async_rst_regwrite", 32'(EX_REGWRITE), 32'd0);
    chk("async_rst_stall", 32'(STALL_OUT), 32'd0);
    cyc();
    RESET = 1;
    set_in(1, ADD_X3, 32'h3004, 32'h11, 32'h22);
    cyc();
    chk("post_rst_valid", 32'(EX_VALID), 32'd1);
    set_in(0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the RV32IM pipeline.
- Takes the IF/ID instruction and drives RS1/RS2 read addresses to the RegisterFile, which returns DATA1/DATA2 combinationally within the cycle.
- Decodes control signals and the immediate, detects load-use hazards, bypasses same-cycle write-back data, and owns the ID/EX pipeline register consumed by EX.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, value of EX_PC while bubbled/reset.

Ports:
- CLK  in  1  pipeline clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- IF_VALID  in  1  IF/ID holds a valid instruction.
- IF_INSTR  in  32  instruction from IF/ID.
- IF_PC  in  32  PC of IF_INSTR.
- FLUSH  in  1  EX resolved taken branch/jump; squash ID.
- EX_STALL  in  1  EX busy (e.g. iterative divide); hold ID/EX.
- STALL_OUT  out  1  to PC/IF: hold IF/ID this cycle.
- RS1  out  5  RegisterFile read address 1 = IF_INSTR[19:15].
- RS2  out  5  RegisterFile read address 2 = IF_INSTR[24:20].
- DATA1, DATA2  in  32 each  RegisterFile read data.
- WB_WRITEENABLE  in  1  write-back write strobe (same signal feeding RegisterFile).
- WB_WRITEADDRESS  in  5  write-back destination.
- WB_WRITEDATA  in  32  write-back data.
- EX_VALID  out  1  ID/EX holds a real instruction.
- EX_PC, EX_DATA1, EX_DATA2, EX_IMM  out  32 each  registered operands.
- EX_RS1, EX_RS2, EX_RD  out  5 each  registered register indices (for EX forwarding).
- EX_ALUOP  out  5  ALU/MULDIV operation code.
- EX_FUNCT3  out  3  raw funct3 (load/store width, branch type).
- EX_ALUSRC  out  1  operand B = EX_IMM.
- EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_BRANCH, EX_JUMP, EX_MULDIV, EX_ILLEGAL  out  1 each  control.

Behaviour:
- Reset (RESET=0, async):
  - all EX_* outputs = 0, except EX_PC = RESET_PC.
  - STALL_OUT = 0.
- RS1/RS2: purely combinational from IF_INSTR, independent of IF_VALID.
- Load-use hazard, combinational:
  - hazard = EX_VALID & EX_MEMREAD & EX_RD!=0 & ((use_rs1 & EX_RD==RS1) | (use_rs2 & EX_RD==RS2)).
  - use_rs1: all opcodes except LUI, AUIPC, JAL.
  - use_rs2: R-type, STORE, BRANCH.
- STALL_OUT = (hazard & IF_VALID & ~FLUSH) | EX_STALL.
- Posedge update, highest priority first:
  1. EX_STALL=1: ID/EX holds all values; FLUSH is ignored (EX must never assert FLUSH while EX_STALL=1; bench asserts this).
  2. FLUSH=1, or IF_VALID=0, or hazard: insert bubble. EX_VALID and all control bits = 0; data fields don't-care, driven 0.
  3. Otherwise capture the decoded instruction with EX_VALID=1.
- Write-back bypass, applied at capture:
  - if WB_WRITEENABLE & WB_WRITEADDRESS!=0 & WB_WRITEADDRESS==RS1, EX_DATA1 = WB_WRITEDATA, else DATA1. Same rule for RS2/EX_DATA2.
  - RS==0 always captures 0, regardless of DATA or WB.
- Immediates, all sign-extended from bit 31:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type: EX_IMM = 0.
- Decode:
  - OP (0110011) with funct7=0000001 → EX_MULDIV=1, EX_ALUOP = MUL..REMU.
  - Loads: MEMREAD, REGWRITE, ALUSRC, ALUOP=ADD.
  - Stores: MEMWRITE, ALUSRC.
  - BRANCH: EX_BRANCH.
  - JAL/JALR: EX_JUMP, REGWRITE.
  - LUI: ALUOP=PASSB.
  - AUIPC: ALUOP=ADD with PC operand flag encoded in ALUOP.
  - FENCE/SYSTEM: valid NOP, no REGWRITE.
  - Unknown opcode or bad funct7: EX_ILLEGAL=1, REGWRITE/MEMREAD/MEMWRITE/BRANCH/JUMP = 0, EX_VALID=1.
  - Writes to rd=0: EX_REGWRITE forced 0.
- Latency: exactly 1 cycle IF/ID → ID/EX when not stalled.
- Throughput: 1 instruction/cycle.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants.
  - ALUOP enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, AUIPC, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - immediate-format enum.
  - NOP encoding 32'h00000013.
- One sub-module: imm_gen (combinational, instr → 32-bit immediate by format).

Test Plan:
- Reset mid-stream: RESET=0 asynchronously while EX_VALID=1 → all EX_* = 0 and STALL_OUT = 0 immediately, before the next edge.
- ADDI x1,x0,5 (32'h00500093), IF_VALID=1 → next edge: EX_VALID=1, EX_RD=1, EX_IMM=5, EX_DATA1=0, ALUSRC=1, REGWRITE=1.
- WB bypass:
  - IF_INSTR = ADD x3,x1,x2; DATA1=1111; WB writes x1=32'hA5A5A5A5 in the same cycle → EX_DATA1=A5A5A5A5, EX_DATA2=DATA2.
  - Same cycle with WB_WRITEADDRESS=0 → no bypass.
- Load-use:
  - LW x5,0(x6) then ADD x7,x5,x1 → STALL_OUT=1 for one cycle, one bubble (EX_VALID=0), then ADD captured.
  - With ADD x7,x1,x5 via rs2: same result.
  - LUI x5 following the load: no stall.
- Flush and stall precedence:
  - FLUSH=1 with a valid instr → bubble.
  - EX_STALL=1 for 3 cycles → ID/EX unchanged and STALL_OUT=1 throughout.
- Decode coverage:
  - MUL x4,x2,x3 (32'h02310233) → MULDIV=1, ALUOP=MUL.
  - BEQ imm −8 → EX_IMM=32'hFFFFFFF8.
  - Opcode 7'b1111111 → ILLEGAL=1, REGWRITE=0.
